// File: rtl/direction_pkg.sv
// Packet direction encoding shared by the VNP4 plugin blocks.
//   PF   : packet heads towards a physical-function port
//   CMAC : packet heads towards a CMAC port
package direction_pkg;
  typedef enum logic {
    PF   = 1'b0,
    CMAC = 1'b1
  } direction_t;
endpackage

// File: rtl/egress_switch_pkg.sv
// Types and constants for the egress switch: FSM state encoding, the gap
// inserted between the CMAC and PF halves of the packed user_src/user_dst
// words, and the widths of the destination masks.
package egress_switch_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int        DST_PF_W   = 4;
  localparam int        DST_CMAC_W = 10;
  localparam logic [1:0] USER_GAP  = 2'b00;
endpackage

// File: rtl/axi_stream_if.sv
// AXI-Stream interfaces used around the VNP4 pipeline.
//   axi_stream_vnp4_if : pipeline-side stream with split src/dst user fields
//                        and a direction flag.
//   axi_stream_if      : port-side stream with packed 16-bit src/dst words.
interface axi_stream_vnp4_if;
  logic [511:0] data;
  logic [63:0]  keep;
  logic         last;
  logic         valid;
  logic         ready;
  logic [15:0]  user_size;
  logic [3:0]   user_src_pf;
  logic [9:0]   user_src_cmac;
  logic [3:0]   user_dst_pf;
  logic [9:0]   user_dst_cmac;
  logic         user_to_direction;

  modport master (
    output data, keep, last, valid, user_size, user_src_pf, user_src_cmac,
           user_dst_pf, user_dst_cmac, user_to_direction,
    input  ready
  );
  modport slave (
    input  data, keep, last, valid, user_size, user_src_pf, user_src_cmac,
           user_dst_pf, user_dst_cmac, user_to_direction,
    output ready
  );
endinterface

interface axi_stream_if;
  logic [511:0] data;
  logic [63:0]  keep;
  logic         last;
  logic         valid;
  logic         ready;
  logic [15:0]  user_size;
  logic [15:0]  user_src;
  logic [15:0]  user_dst;

  modport master (
    output data, keep, last, valid, user_size, user_src, user_dst,
    input  ready
  );
  modport slave (
    input  data, keep, last, valid, user_size, user_src, user_dst,
    output ready
  );
endinterface

// File: rtl/egress_route_decode.sv
// Combinational destination decode.
//   dir      : packet direction (PF or CMAC)
//   mask     : destination one-hot-ish mask; PF masks arrive zero-extended
//   routable : a bit is set and its index addresses an existing port
//   index    : position of the lowest set bit of mask
module egress_route_decode
  import direction_pkg::*;
  import egress_switch_pkg::*;
#(
  parameter int NUM_PHYS_FUNC = 1,
  parameter int NUM_CMAC_PORT = 1
) (
  input  direction_t            dir,
  input  logic [DST_CMAC_W-1:0] mask,
  output logic                  routable,
  output logic [3:0]            index
);

  logic       any_set;
  logic [3:0] limit;

  // Scan high to low so the final assignment is the lowest set bit.
  always_comb begin
    index   = 4'd0;
    any_set = 1'b0;
    for (int i = DST_CMAC_W - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index   = 4'(i);
        any_set = 1'b1;
      end
    end
  end

  assign limit    = (dir == CMAC) ? 4'(NUM_CMAC_PORT) : 4'(NUM_PHYS_FUNC);
  assign routable = any_set && (index < limit);

endmodule

// File: rtl/egress_switch.sv
// Egress switch: steers each packet of the VNP4 pipeline output to one PF or
// one CMAC master port, chosen on the first beat and held until last.
// Unroutable packets are swallowed whole and counted.
//   aclk, areset  : clock, synchronous active-high reset
//   s_axis        : pipeline-side input stream
//   m_axis_pf[]   : per-PF output streams
//   m_axis_cmac[] : per-CMAC output streams
//   drop_count    : saturating count of dropped packets
// DROP_CNT_W narrows the internal drop counter (saturation point); the
// output stays 32 bits wide.
module egress_switch
  import direction_pkg::*;
  import egress_switch_pkg::*;
#(
  parameter int NUM_PHYS_FUNC = 1,
  parameter int NUM_CMAC_PORT = 1,
  parameter int DROP_CNT_W    = 32
) (
  input  logic              aclk,
  input  logic              areset,
  axi_stream_vnp4_if.slave  s_axis,
  axi_stream_if.master      m_axis_pf   [NUM_PHYS_FUNC],
  axi_stream_if.master      m_axis_cmac [NUM_CMAC_PORT],
  output logic [31:0]       drop_count
);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                  state_q;
  direction_t              in_dir;
  logic [DST_CMAC_W-1:0]   in_mask;
  logic                    routable;
  logic [3:0]              in_idx;

  logic [NUM_PHYS_FUNC-1:0] pf_ready;
  logic [NUM_CMAC_PORT-1:0] cmac_ready;
  logic                     sel_ready;
  logic                     adv;
  logic                     is_first;
  logic                     drop_beat;
  logic                     s_ready;
  logic                     accept;
  logic                     load;

  logic [511:0]            data_p1;
  logic [63:0]             keep_p1;
  logic                    last_p1;
  logic [15:0]             size_p1;
  logic [15:0]             src_p1;
  logic [15:0]             dst_p1;
  logic                    vld_p1;
  direction_t              dir_p1;
  logic [3:0]              idx_p1;
  logic [DROP_CNT_W-1:0]   drop_cnt_q;

  assign in_dir  = direction_t'(s_axis.user_to_direction);
  assign in_mask = (in_dir == CMAC) ? s_axis.user_dst_cmac
                                    : {{(DST_CMAC_W-DST_PF_W){1'b0}}, s_axis.user_dst_pf};

  egress_route_decode #(
    .NUM_PHYS_FUNC (NUM_PHYS_FUNC),
    .NUM_CMAC_PORT (NUM_CMAC_PORT)
  ) u_decode (
    .dir      (in_dir),
    .mask     (in_mask),
    .routable (routable),
    .index    (in_idx)
  );

  // Ready of whichever port currently owns the output register.
  always_comb begin
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_PHYS_FUNC; i++)
      if (dir_p1 == PF && idx_p1 == 4'(i)) sel_ready = pf_ready[i];
    for (int i = 0; i < NUM_CMAC_PORT; i++)
      if (dir_p1 == CMAC && idx_p1 == 4'(i)) sel_ready = cmac_ready[i];
  end

  // A held beat that is draining this cycle frees the register for a new one,
  // which also lets packet B's first beat load as packet A's last beat leaves.
  assign adv       = !vld_p1 || sel_ready;
  assign is_first  = (state_q == IDLE);
  assign drop_beat = (state_q == DROP) || (is_first && !routable);
  assign s_ready   = drop_beat || adv;
  assign accept    = s_axis.valid && s_ready;
  assign load      = accept && !drop_beat;

  assign s_axis.ready = s_ready;
  assign drop_count   = 32'(drop_cnt_q);

  // ---- stage p0 -> p1: control ----
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      vld_p1     <= 1'b0;
      dir_p1     <= PF;
      idx_p1     <= 4'd0;
      drop_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept && !s_axis.last) state_q <= routable ? FWD : DROP;
        FWD:  if (accept && s_axis.last)  state_q <= IDLE;
        DROP: if (accept && s_axis.last)  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (load)     vld_p1 <= 1'b1;
      else if (adv) vld_p1 <= 1'b0;

      if (load && is_first) begin
        dir_p1 <= in_dir;
        idx_p1 <= in_idx;
      end

      if (accept && is_first && !routable) drop_cnt_q <= sat_inc(drop_cnt_q);
    end
  end

  // ---- stage p0 -> p1: data ----
  always_ff @(posedge aclk) begin
    if (load) begin
      data_p1 <= s_axis.data;
      keep_p1 <= s_axis.keep;
      last_p1 <= s_axis.last;
      size_p1 <= s_axis.user_size;
      src_p1  <= {s_axis.user_src_cmac, USER_GAP, s_axis.user_src_pf};
      dst_p1  <= {s_axis.user_dst_cmac, USER_GAP, s_axis.user_dst_pf};
    end
  end

  for (genvar g = 0; g < NUM_PHYS_FUNC; g++) begin : g_pf
    assign m_axis_pf[g].valid     = vld_p1 && (dir_p1 == PF) && (idx_p1 == 4'(g));
    assign m_axis_pf[g].data      = data_p1;
    assign m_axis_pf[g].keep      = keep_p1;
    assign m_axis_pf[g].last      = last_p1;
    assign m_axis_pf[g].user_size = size_p1;
    assign m_axis_pf[g].user_src  = src_p1;
    assign m_axis_pf[g].user_dst  = dst_p1;
    assign pf_ready[g]            = m_axis_pf[g].ready;
  end

  for (genvar g = 0; g < NUM_CMAC_PORT; g++) begin : g_cmac
    assign m_axis_cmac[g].valid     = vld_p1 && (dir_p1 == CMAC) && (idx_p1 == 4'(g));
    assign m_axis_cmac[g].data      = data_p1;
    assign m_axis_cmac[g].keep      = keep_p1;
    assign m_axis_cmac[g].last      = last_p1;
    assign m_axis_cmac[g].user_size = size_p1;
    assign m_axis_cmac[g].user_src  = src_p1;
    assign m_axis_cmac[g].user_dst  = dst_p1;
    assign cmac_ready[g]            = m_axis_cmac[g].ready;
  end

endmodule

// File: doc/egress_switch.md
# egress_switch

Egress side of the shared 250 MHz TX/RX plugin: accepts the single `axi_stream_vnp4_if` stream leaving the VNP4 pipeline and steers each packet to one physical-function or one CMAC `axi_stream_if` master port. The route is set by the packet's direction and destination user fields. Each packet is routed on its first beat and held until `last`. Packets with an unroutable destination are dropped whole and counted. There is one registered output stage.

## Interface
- `NUM_PHYS_FUNC`, default 1: number of PF master ports; 1..4.
- `NUM_CMAC_PORT`, default 1: number of CMAC master ports; 1..10.
- `aclk`, input, 1: single clock.
- `areset`, input, 1: reset; synchronous, active-high.
- `s_axis`, `axi_stream_vnp4_if.slave`: pipeline output. Uses data[511:0], keep[63:0], last, valid, ready, user_size[15:0], user_src_pf[3:0], user_src_cmac[9:0], user_dst_pf[3:0], user_dst_cmac[9:0], user_to_direction.
- `m_axis_pf[NUM_PHYS_FUNC]`, `axi_stream_if.master`: per-PF output. Carries data, keep, last, valid, ready, user_size, user_src[15:0], user_dst[15:0].
- `m_axis_cmac[NUM_CMAC_PORT]`, `axi_stream_if.master`: per-CMAC output, same fields as the PF ports.
- `drop_count`, output, 32: saturating count of dropped packets.

## Operation
- Direction encoding comes from `direction_pkg`: `PF`, `CMAC`.
- Destination decode runs on the first beat of each packet, combinationally from the current `s_axis` fields:
  - direction `PF`: index = lowest set bit of user_dst_pf; routable iff a bit is set and index < NUM_PHYS_FUNC.
  - direction `CMAC`: same rule on user_dst_cmac against NUM_CMAC_PORT.
- FSM states:
  - IDLE (awaiting first beat):
    - routable beat accepted: forward it, latch direction and index; go to FWD if !last, else stay in IDLE.
    - unroutable beat: always accepted and discarded; drop_count += 1 (saturates at 0xFFFF_FFFF); go to DROP if !last.
  - FWD: every beat goes to the latched port; `last` returns to IDLE.
  - DROP: `s_axis.ready`=1 and beats are discarded; `last` returns to IDLE.
- Output register holds data, keep, last, user fields, out_valid, latched direction and index. Only the selected port sees valid=1; all other ports' valid=0. data/keep/user are broadcast to every port.
- Output user fields:
  - user_src = {user_src_cmac, 2'b00, user_src_pf}
  - user_dst = {user_dst_cmac, 2'b00, user_dst_pf}
  - user_size is passed through.
- `s_axis.ready`:
  - 1 in DROP, and in IDLE when the decode is unroutable;
  - otherwise (!out_valid || selected port ready).
  - Combinational path from m ready to s ready is allowed.
- user_size is not checked against the beat count.

## Timing
- Latency: a beat accepted at edge N is valid on its master port after edge N. Full rate when the destination is continuously ready.
- The output register advances when (!out_valid || selected ready). A new beat may load in the same cycle the held beat drains.
- Back-to-back packets to different ports: the first beat of packet B loads only once packet A's last beat is handed off or is draining in that cycle. No interleaving within a port.
- Reset values: state=IDLE, out_valid=0, every m valid=0, drop_count=0; data/keep/user are don't-care.
- Reset mid-packet: the output beat is lost. The next accepted `s_axis` beat is decoded as a first beat.
- `user_to_direction` and `user_dst_*` are ignored outside IDLE.

## Structure
- `egress_switch_pkg`: state enum (IDLE, FWD, DROP), the 2'b00 gap constant, and DST_PF_W=4 / DST_CMAC_W=10.
- Sub-module `egress_route_decode` (combinational): direction and mask in; routable and index out. Reused for range checks.
- Top level: FSM, output register, valid demux, ready mux, counter.

## Test plan
- NUM_PHYS_FUNC=2, NUM_CMAC_PORT=2; 3-beat packet, dir=CMAC, dst_cmac=0b10 -> 3 beats on m_axis_cmac[1] only, one cycle later; user_dst=0x0080; drop_count=0.
- Single-beat packet, dir=PF, dst_pf=0b0110 -> routed to PF[1] (lowest set bit).
- dir=PF, dst_pf=0b0100 with NUM_PHYS_FUNC=2 -> all 4 beats accepted with ready=1, no master valid, drop_count=1. Next packet routes normally.
- CMAC[0] ready deasserted for 5 cycles mid-packet -> data held stable, s_axis.ready=0, no beat lost or duplicated. Concurrent PF traffic waits.
- drop_count preloaded near saturation by forcing 0xFFFF_FFFF drops (or via a reduced-width bench parameter) -> stays at all-ones.
- areset pulsed during beat 2 of a 4-beat packet -> all valid=0 the next cycle. Beat 3 is decoded as a new first beat.
